// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - execute-stage MULT/DIV/MTHI/MTLO unit owning HI/LO
module hilo_muldiv_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic        hi_write_enable,
  output logic        lo_write_enable,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic [31:0] hi_reg,
  output logic [31:0] lo_reg
);

  localparam int CNT_MAX = (DIV_ITERS > MUL_CYCLES) ? DIV_ITERS : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_signed;
  logic [31:0]      r_quo;
  logic [31:0]      r_rem;
  logic [31:0]      r_div;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_hi_we;
  logic             r_lo_we;
  logic [31:0]      r_hi_data;
  logic [31:0]      r_lo_data;
  logic [31:0]      r_hi_reg;
  logic [31:0]      r_lo_reg;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_div_zero;
  logic        w_div_signed;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;

  assign w_accept     = (r_state == S_IDLE) && start && !cancel;
  assign w_is_mul     = (op == 3'd0) || (op == 3'd1);
  assign w_is_div     = (op == 3'd2) || (op == 3'd3);
  assign w_is_mthi    = (op == 3'd4);
  assign w_is_mtlo    = (op == 3'd5);
  assign w_div_zero   = (rt_data == 32'd0);
  assign w_div_signed = (op == 3'd2);
  assign w_rs_neg     = w_div_signed && rs_data[31];
  assign w_rt_neg     = w_div_signed && rt_data[31];
  assign w_rs_abs     = w_rs_neg ? (~rs_data + 32'd1) : rs_data;
  assign w_rt_abs     = w_rt_neg ? (~rt_data + 32'd1) : rt_data;

  // With a one-cycle multiply the product is taken straight from the issue operands.
  logic [31:0] w_mul_a;
  logic [31:0] w_mul_b;
  logic        w_mul_signed;
  logic signed [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_product;

  assign w_mul_a      = (r_state == S_IDLE) ? rs_data : r_a;
  assign w_mul_b      = (r_state == S_IDLE) ? rt_data : r_b;
  assign w_mul_signed = (r_state == S_IDLE) ? (op == 3'd0) : r_signed;
  assign w_prod_s     = $signed({{32{w_mul_a[31]}}, w_mul_a}) * $signed({{32{w_mul_b[31]}}, w_mul_b});
  assign w_prod_u     = {32'd0, w_mul_a} * {32'd0, w_mul_b};
  assign w_product    = w_mul_signed ? $unsigned(w_prod_s) : w_prod_u;

  // Restoring step: partial remainder shifted left with the next dividend bit.
  logic [32:0] w_shift;
  logic        w_fits;
  logic [31:0] w_diff;
  logic [31:0] w_fix_quo;
  logic [31:0] w_fix_rem;

  assign w_shift   = {r_rem, r_quo[31]};
  assign w_fits    = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[31:0] - r_div;
  assign w_fix_quo = r_q_neg ? (~r_quo + 32'd1) : r_quo;
  assign w_fix_rem = r_r_neg ? (~r_rem + 32'd1) : r_rem;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: counters hitting their last step hand over to FIX/WRITE; cancel aborts before WRITE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_next = (MUL_CYCLES == 1) ? S_WRITE : S_MUL;
        end else if (w_accept && w_is_div) begin
          w_state_next = w_div_zero ? S_FIX : S_DIV;
        end
      end
      S_MUL: begin
        if (cancel) begin
          w_state_next = S_IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_next = S_WRITE;
        end
      end
      S_DIV: begin
        if (cancel) begin
          w_state_next = S_IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = cancel ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, multiply countdown and one divide iteration per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_a      <= rs_data;
            r_b      <= rt_data;
            r_signed <= (op == 3'd0);
            r_cnt    <= CNT_W'(MUL_CYCLES - 1);
          end else if (w_accept && w_is_div) begin
            r_div <= w_rt_abs;
            if (w_div_zero) begin
              // Preload the final answer so FIX passes it through untouched.
              r_quo   <= 32'hFFFF_FFFF;
              r_rem   <= rs_data;
              r_q_neg <= 1'b0;
              r_r_neg <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_quo   <= w_rs_abs;
              r_rem   <= '0;
              r_q_neg <= w_rs_neg ^ w_rt_neg;
              r_r_neg <= w_rs_neg;
              r_cnt   <= CNT_W'(DIV_ITERS);
            end
          end
        end
        S_MUL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (r_cnt != '0) begin
            r_rem <= w_fits ? w_diff : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_fits};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write port: one-cycle pulses; data holds its last value between pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi_we   <= 1'b0;
      r_lo_we   <= 1'b0;
      r_hi_data <= '0;
      r_lo_data <= '0;
    end else begin
      r_hi_we <= 1'b0;
      r_lo_we <= 1'b0;
      if (w_state_next == S_WRITE) begin
        r_hi_we <= 1'b1;
        r_lo_we <= 1'b1;
        if (r_state == S_FIX) begin
          r_hi_data <= w_fix_rem;
          r_lo_data <= w_fix_quo;
        end else begin
          r_hi_data <= w_product[63:32];
          r_lo_data <= w_product[31:0];
        end
      end else if (w_accept && w_is_mthi) begin
        r_hi_we   <= 1'b1;
        r_hi_data <= rs_data;
      end else if (w_accept && w_is_mtlo) begin
        r_lo_we   <= 1'b1;
        r_lo_data <= rs_data;
      end
    end
  end

  // Architectural HI/LO commit on the edge that closes a write pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi_reg <= '0;
      r_lo_reg <= '0;
    end else begin
      if (r_hi_we) begin
        r_hi_reg <= r_hi_data;
      end
      if (r_lo_we) begin
        r_lo_reg <= r_lo_data;
      end
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign hi_write_enable = r_hi_we;
  assign lo_write_enable = r_lo_we;
  assign hi_data         = r_hi_data;
  assign lo_data         = r_lo_data;
  assign hi_reg          = r_hi_reg;
  assign lo_reg          = r_lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_ITERS  = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic        hi_write_enable;
  logic        lo_write_enable;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  hilo_muldiv_unit #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_ITERS (DIV_ITERS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .cancel         (cancel),
    .busy           (busy),
    .hi_write_enable(hi_write_enable),
    .lo_write_enable(lo_write_enable),
    .hi_data        (hi_data),
    .lo_data        (lo_data),
    .hi_reg         (hi_reg),
    .lo_reg         (lo_reg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hwe;
    logic        lwe;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi_reg;
  logic [31:0] m_lo_reg;
  logic [31:0] m_hd;
  logic [31:0] m_ld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural results from plain 64-bit arithmetic.
  function automatic vec_t model(input logic [2:0] mop, input logic [31:0] rs, input logic [31:0] rt);
    vec_t v;
    longint q;
    longint r;
    logic [63:0] p;
    v = '{mop, rs, rt, 32'd0, 32'd0, 1'b0, 1'b0, 0};
    case (mop)
      3'd0, 3'd1: begin
        if (mop == 3'd0) p = longint'($signed(rs)) * longint'($signed(rt));
        else             p = {32'd0, rs} * {32'd0, rt};
        v.hi = p[63:32]; v.lo = p[31:0]; v.hwe = 1; v.lwe = 1; v.lat = MUL_CYCLES;
      end
      3'd2, 3'd3: begin
        v.hwe = 1; v.lwe = 1;
        if (rt == 32'd0) begin
          v.hi = rs; v.lo = 32'hFFFF_FFFF; v.lat = 2;
        end else begin
          if (mop == 3'd2) begin
            q = longint'($signed(rs)) / longint'($signed(rt));
            r = longint'($signed(rs)) % longint'($signed(rt));
          end else begin
            q = longint'({32'd0, rs}) / longint'({32'd0, rt});
            r = longint'({32'd0, rs}) % longint'({32'd0, rt});
          end
          v.hi = r[31:0]; v.lo = q[31:0]; v.lat = DIV_ITERS + 2;
        end
      end
      3'd4: begin v.hi = rs; v.hwe = 1; v.lat = 1; end
      3'd5: begin v.lo = rs; v.lwe = 1; v.lat = 1; end
      default: begin end
    endcase
    return v;
  endfunction

  // Issue one op; cycle 1 is the first cycle after the start edge. intrude>0 issues a stray MULTU then.
  task automatic run_op(input string tag, input vec_t v, input int intrude);
    int  cyc;
    int  limit;
    bit  seen;
    bit  busy_ok;
    logic multi;
    multi = (v.op <= 3'd3);
    limit = (v.lat == 0) ? 4 : 60;
    @(negedge clock);
    start = 1'b1; op = v.op; rs_data = v.rs; rt_data = v.rt;
    @(negedge clock);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    cyc = 1; seen = 0; busy_ok = 1;
    while (cyc <= limit) begin
      if (hi_write_enable || lo_write_enable) begin
        seen = 1;
        break;
      end
      if (busy !== multi) busy_ok = 0;
      start = (intrude != 0 && cyc == intrude);
      op    = 3'd1;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
    if (v.lat == 0) begin
      check({tag, "_no_pulse"}, 32'(seen), 32'd0);
    end else begin
      check({tag, "_latency"}, cyc, v.lat);
      check({tag, "_hi_we"}, 32'(hi_write_enable), 32'(v.hwe));
      check({tag, "_lo_we"}, 32'(lo_write_enable), 32'(v.lwe));
      check({tag, "_busy_at_pulse"}, 32'(busy), 32'(multi));
      if (v.hwe) begin m_hd = v.hi; m_hi_reg = v.hi; end
      if (v.lwe) begin m_ld = v.lo; m_lo_reg = v.lo; end
      check({tag, "_hi_data"}, hi_data, m_hd);
      check({tag, "_lo_data"}, lo_data, m_ld);
      @(negedge clock);
    end
    check({tag, "_hi_reg"}, hi_reg, m_hi_reg);
    check({tag, "_lo_reg"}, lo_reg, m_lo_reg);
    check({tag, "_we_clear"}, {30'd0, hi_write_enable, lo_write_enable}, 32'd0);
    check({tag, "_hold_hi"}, hi_data, m_hd);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[11];
  vec_t rv;
  int   seen_c;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b1, 4};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b1, 4};
    tbl[2]  = '{3'd3, 32'd100,       32'd7,        32'd2,         32'd14,        1'b1, 1'b1, 34};
    tbl[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b1, 34};
    tbl[4]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b1, 1'b1, 34};
    tbl[5]  = '{3'd2, 32'd123,       32'd0,        32'd123,       32'hFFFF_FFFF, 1'b1, 1'b1, 2};
    tbl[6]  = '{3'd4, 32'hAAAA_5555, 32'd0,        32'hAAAA_5555, 32'd0,         1'b1, 1'b0, 1};
    tbl[7]  = '{3'd5, 32'h1234_5678, 32'd0,        32'd0,         32'h1234_5678, 1'b0, 1'b1, 1};
    tbl[8]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b1, 1'b1, 34};
    tbl[9]  = '{3'd3, 32'd5,         32'd9,        32'd5,         32'd0,         1'b1, 1'b1, 34};
    tbl[10] = '{3'd6, 32'hDEAD_BEEF, 32'd3,        32'd0,         32'd0,         1'b0, 1'b0, 0};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    m_hi_reg = '0; m_lo_reg = '0; m_hd = '0; m_ld = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_we", {30'd0, hi_write_enable, lo_write_enable}, 32'd0);
    check("reset_hi_reg", hi_reg, 32'd0);
    check("reset_lo_reg", lo_reg, 32'd0);
    check("reset_hi_data", hi_data, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_op($sformatf("vec%0d", i), tbl[i], 0);

    // A start during a DIV is ignored and the DIV result stands.
    run_op("div_intrude", tbl[2], 5);

    // Cancel at DIV cycle 10: no pulse, registers unchanged.
    @(negedge clock);
    start = 1'b1; op = 3'd2; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    seen_c = 0;
    for (int k = 0; k < 40; k++) begin
      if (hi_write_enable || lo_write_enable) seen_c = 1;
      @(negedge clock);
    end
    check("cancel_no_pulse", seen_c, 0);
    check("cancel_hi_reg", hi_reg, m_hi_reg);
    check("cancel_lo_reg", lo_reg, m_lo_reg);

    // Cancel together with start in IDLE drops the request (multi-cycle and MTHI).
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      start = 1'b1; cancel = 1'b1; op = (j == 0) ? 3'd0 : 3'd4; rs_data = 32'h5A5A_0001; rt_data = 32'd9;
      @(negedge clock);
      start = 1'b0; cancel = 1'b0;
      seen_c = 0;
      for (int k = 0; k < 6; k++) begin
        if (hi_write_enable || lo_write_enable || busy) seen_c = 1;
        @(negedge clock);
      end
      check($sformatf("cancel_start%0d_dropped", j), seen_c, 0);
      check($sformatf("cancel_start%0d_hi_reg", j), hi_reg, m_hi_reg);
    end

    // Asynchronous reset mid-MUL clears everything before any clock edge.
    @(negedge clock);
    start = 1'b1; op = 3'd0; rs_data = 32'd77; rt_data = 32'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_we", {30'd0, hi_write_enable, lo_write_enable}, 32'd0);
    check("areset_hi_reg", hi_reg, 32'd0);
    check("areset_lo_reg", lo_reg, 32'd0);
    check("areset_hi_data", hi_data, 32'd0);
    check("areset_lo_data", lo_data, 32'd0);
    m_hi_reg = '0; m_lo_reg = '0; m_hd = '0; m_ld = '0;
    @(negedge clock);
    reset = 1'b0;
    run_op("after_reset", tbl[0], 0);

    // Randomized ops against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  rop;
      logic [31:0] a;
      logic [31:0] b;
      rop = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'h0000_00FF;
      rv = model(rop, a, b);
      run_op($sformatf("rand%0d_op%0d", i, rop), rv, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage producer of HI/LO writes. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers.
- Publishes the one-cycle HI/LO write-port values that the decode-stage forwarding logic consumes as exe-stage hi/lo data and enables.
- Raises busy so the hazard logic stalls issue while a multi-cycle operation runs.

Parameters:
- MUL_CYCLES, 4, cycles from accepted MULT/MULTU start to write pulse (min 1).
- DIV_ITERS, 32, restoring-division iterations (fixed at datapath width).

Ports:
- clock  in  1  all state changes on posedge clock
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled on posedge; ignored while busy
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 ignored
- rs_data  in  32  operand A / dividend / MTHI-MTLO source
- rt_data  in  32  operand B / divisor
- cancel  in  1  pipeline flush; aborts the in-flight op
- busy  out  1  high while a MULT/MULTU/DIV/DIVU is in flight
- hi_write_enable  out  1  one-cycle HI write pulse
- lo_write_enable  out  1  one-cycle LO write pulse
- hi_data  out  32  HI write value; valid while hi_write_enable
- lo_data  out  32  LO write value; valid while lo_write_enable
- hi_reg  out  32  architectural HI
- lo_reg  out  32  architectural LO

Behaviour:
- Reset (async): state IDLE; busy, both write enables, hi_data, lo_data, hi_reg, lo_reg all 0; counters 0.
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE:
  - start with op 0/1: latch operands; counter=MUL_CYCLES-1; go to MUL.
  - start with op 2/3: latch abs operands (abs only for DIV) and result signs; counter=DIV_ITERS; go to DIV.
  - start with op 4/5: no state change. Next cycle drives hi_write_enable (or lo_write_enable) with hi_data/lo_data = rs_data; busy stays 0.
  - start with op 6/7: no effect.
- MUL:
  - Product = 64-bit signed (MULT) or unsigned (MULTU) product of the latched operands.
  - Decrement counter; at 0 go to WRITE.
  - Write pulse asserted exactly MUL_CYCLES cycles after the start edge.
- DIV:
  - One restoring shift/subtract per cycle; counter decrements; at 0 go to FIX.
  - FIX applies signs for DIV: quotient negated if operand signs differ; remainder takes the dividend's sign. Then go to WRITE.
  - Write pulse asserted DIV_ITERS+2 cycles after the start edge.
- Divide by zero: no trap; bypasses iteration; WRITE 2 cycles after start with lo_data=32'hFFFFFFFF and hi_data=dividend (raw rs_data).
- WRITE:
  - hi_write_enable = lo_write_enable = 1 for one cycle; hi_data = product[63:32] or remainder; lo_data = product[31:0] or quotient.
  - hi_reg/lo_reg take those values on the closing edge.
  - Return to IDLE.
- busy: 1 from the cycle after an accepted multi-cycle start through the WRITE cycle inclusive.
  - start in the WRITE cycle is ignored; issue logic waits for busy=0.
- Outside WRITE and the MTHI/MTLO pulse cycle, both write enables are 0 and hi_data/lo_data hold their last values.
- cancel:
  - In MUL/DIV/FIX: go to IDLE next edge; no write pulse; hi_reg/lo_reg unchanged.
  - In WRITE: ignored; the write completes.
  - With start in IDLE: cancel wins; request dropped.
- Reset mid-operation: immediate return to the reset values above; no partial write.

Test Plan:
- MULT rs=32'hFFFFFFFD (-3), rt=5, MUL_CYCLES=4 -> write pulse 4 cycles after start; hi=FFFFFFFF, lo=FFFFFFF1; busy high 4 cycles.
- MULTU rs=rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; hi_reg/lo_reg match the cycle after.
- DIVU 100/7 -> lo=14, hi=2, pulse at cycle 34. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 7/-2 -> lo=FFFFFFFD, hi=1.
- DIV rs=123, rt=0 -> pulse at cycle 2; lo=FFFFFFFF, hi=123.
- MTHI rs=AAAA5555 -> hi_write_enable only, next cycle; busy 0. A start issued during a DIV is ignored, and the DIV result is unaffected.
- cancel at DIV cycle 10 -> no write pulse; regs unchanged. Async reset mid-MUL -> all outputs 0 immediately; new MULT after reset works.
